// File: rtl/vga_line_fetch_if.sv
// vga_line_fetch_if: pixel-memory read bus (request/grant, in-order single-outstanding read data).
// Rev 1.0
`default_nettype none

interface vga_line_fetch_if #(
  parameter int ADDR_W = 17
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic [7:0]        mem_rdata;
  logic              mem_rvalid;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rdata, mem_rvalid
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rdata, mem_rvalid
  );
endinterface

`default_nettype wire

// File: rtl/vga_line_fetch.sv
// vga_line_fetch: ping-pong line buffer feeding vga_ctrl with a 2x-doubled 320x240 grayscale image.
// Rev 1.0
`default_nettype none

module vga_line_fetch #(
  parameter int IMG_W   = 320,
  parameter int IMG_H   = 240,
  parameter int ADDR_W  = 17,
  parameter int V_TOTAL = 525
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [9:0] px,
  input  wire logic [9:0] py,
  output logic      [7:0] o_red,
  output logic      [7:0] o_green,
  output logic      [7:0] o_blue,
  vga_line_fetch_if.master mem,
  output logic            fetch_err
);

  localparam int C_COL_W = $clog2(IMG_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  logic [C_COL_W-1:0]  r_col;
  logic [ADDR_W-1:0]   r_row_base;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_valid;
  logic                r_bank;
  logic                r_req;
  logic                r_err;
  logic [7:0]          r_bank0 [IMG_W];
  logic [7:0]          r_bank1 [IMG_W];

  logic                w_trig_frame;
  logic                w_trig_row;
  logic                w_trig;
  logic                w_trig_bank;
  logic [ADDR_W-1:0]   w_new_base;
  logic [C_COL_W-1:0]  w_col_inc;
  logic                w_last;
  logic                w_wr_en;
  logic                w_disp_bank;
  logic [C_COL_W-1:0]  w_pcol;
  logic                w_show;
  logic [7:0]          w_gray;

  // Row r+1 lands in bank (r+1)[0]; with r = py/2 that is the inverse of py[1].
  assign w_trig_frame = (px == 10'd0) && (py == 10'(V_TOTAL - 1));
  assign w_trig_row   = (px == 10'd0) && (py < 10'(2 * IMG_H - 2)) && !py[0];
  assign w_trig       = w_trig_frame || w_trig_row;
  assign w_trig_bank  = w_trig_frame ? 1'b0 : ~py[1];
  assign w_new_base   = w_trig_frame ? '0 : r_row_base + ADDR_W'(IMG_W);
  assign w_col_inc    = r_col + 1'b1;
  assign w_last       = (r_col == C_COL_W'(IMG_W - 1));
  assign w_wr_en      = (r_state == S_WAIT) && mem.mem_rvalid && !w_trig;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_col      <= '0;
      r_row_base <= '0;
      r_addr     <= '0;
      r_valid    <= 2'b00;
      r_bank     <= 1'b0;
      r_req      <= 1'b0;
      r_err      <= 1'b0;
    end else if (w_trig) begin
      if (r_state != S_IDLE) begin
        r_err <= 1'b1;
      end
      r_valid[w_trig_bank] <= 1'b0;
      r_bank     <= w_trig_bank;
      r_row_base <= w_new_base;
      r_col      <= '0;
      r_addr     <= w_new_base;
      r_req      <= 1'b1;
      r_state    <= S_REQ;
    end else begin
      case (r_state)
        S_REQ: begin
          if (mem.mem_gnt) begin
            r_req   <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem.mem_rvalid) begin
            if (w_last) begin
              r_valid[r_bank] <= 1'b1;
              r_state         <= S_IDLE;
            end else begin
              r_col   <= w_col_inc;
              r_addr  <= r_row_base + ADDR_W'(w_col_inc);
              r_req   <= 1'b1;
              r_state <= S_REQ;
            end
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Line-buffer storage carries no reset; the valid bits gate its use.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (r_bank) begin
        r_bank1[r_col] <= mem.mem_rdata;
      end else begin
        r_bank0[r_col] <= mem.mem_rdata;
      end
    end
  end

  assign w_disp_bank = py[1];
  assign w_pcol      = px[C_COL_W:1];
  assign w_show      = (px < 10'(2 * IMG_W)) && (py < 10'(2 * IMG_H)) && r_valid[w_disp_bank];

  always_comb begin
    w_gray = 8'd0;
    if (w_show) begin
      w_gray = w_disp_bank ? r_bank1[w_pcol] : r_bank0[w_pcol];
    end
  end

  assign o_red        = w_gray;
  assign o_green      = w_gray;
  assign o_blue       = w_gray;
  assign mem.mem_req  = r_req;
  assign mem.mem_addr = r_addr;
  assign fetch_err    = r_err;

endmodule

`default_nettype wire
